// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state codes for the sequencer, ball, brick and VGA blocks
package game_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        MAIN_MENU   = 3'd0,
        SERVE       = 3'd1,
        PLAY        = 3'd2,
        LIFE_LOST   = 3'd3,
        LEVEL_CLEAR = 3'd4,
        END_SCREEN  = 3'd5
    } game_state_e;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - 1-bit rising-edge detector with configurable reset value
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clock) begin
        if (!reset) begin
            prev <= RESET_VAL;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - brick-breaker play controller: game state, lives, level and load pulses
module game_sequencer
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int NUM_LEVELS  = 2,
    parameter int PAUSE_TICKS = 60
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               key_space,
    input  logic               ball_lost,
    input  logic               all_cleared,
    output logic [STATE_W-1:0] state,
    output logic               ball_move,
    output logic               ball_load,
    output logic               bricks_load,
    output logic [1:0]         lives,
    output logic [1:0]         level,
    output logic               win
);

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] state_n;
    logic [7:0]         pause_r;
    logic [7:0]         pause_n;
    logic [1:0]         lives_n;
    logic [1:0]         level_n;
    logic               win_n;
    logic               ball_load_n;
    logic               bricks_load_n;
    logic               ball_move_n;
    logic               space_press;
    logic               pause_done;

    // Edge register resets high so a key held through reset never counts as a press.
    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_space_edge (
        .clock (clock),
        .reset (reset),
        .level (key_space),
        .rise  (space_press)
    );

    assign pause_done = tick && (pause_r == 8'(PAUSE_TICKS - 1));

    always_comb begin
        state_n       = state_r;
        pause_n       = pause_r;
        lives_n       = lives;
        level_n       = level;
        win_n         = win;
        ball_load_n   = 1'b0;
        bricks_load_n = 1'b0;

        case (state_r)
            MAIN_MENU: begin
                if (space_press) begin
                    state_n       = SERVE;
                    lives_n       = 2'(LIVES);
                    level_n       = 2'd0;
                    win_n         = 1'b0;
                    ball_load_n   = 1'b1;
                    bricks_load_n = 1'b1;
                end
            end
            SERVE: begin
                if (space_press) begin
                    state_n = PLAY;
                end
            end
            PLAY: begin
                if (all_cleared) begin
                    state_n = LEVEL_CLEAR;
                    pause_n = 8'd0;
                end else if (ball_lost) begin
                    state_n = LIFE_LOST;
                    pause_n = 8'd0;
                    if (lives != 2'd0) begin
                        lives_n = lives - 2'd1;
                    end
                end
            end
            LIFE_LOST: begin
                if (tick) begin
                    pause_n = pause_r + 8'd1;
                end
                if (pause_done) begin
                    if (lives == 2'd0) begin
                        state_n = END_SCREEN;
                        win_n   = 1'b0;
                    end else begin
                        state_n     = SERVE;
                        ball_load_n = 1'b1;
                    end
                end
            end
            LEVEL_CLEAR: begin
                if (tick) begin
                    pause_n = pause_r + 8'd1;
                end
                if (pause_done) begin
                    if (level == 2'(NUM_LEVELS - 1)) begin
                        state_n = END_SCREEN;
                        win_n   = 1'b1;
                    end else begin
                        state_n       = SERVE;
                        level_n       = level + 2'd1;
                        ball_load_n   = 1'b1;
                        bricks_load_n = 1'b1;
                    end
                end
            end
            END_SCREEN: begin
                if (space_press) begin
                    state_n = MAIN_MENU;
                end
            end
            default: begin
                state_n = MAIN_MENU;
            end
        endcase

        ball_move_n = (state_n == PLAY);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= MAIN_MENU;
            pause_r     <= 8'd0;
            lives       <= 2'd0;
            level       <= 2'd0;
            win         <= 1'b0;
            ball_move   <= 1'b0;
            ball_load   <= 1'b0;
            bricks_load <= 1'b0;
        end else begin
            state_r     <= state_n;
            pause_r     <= pause_n;
            lives       <= lives_n;
            level       <= level_n;
            win         <= win_n;
            ball_move   <= ball_move_n;
            ball_load   <= ball_load_n;
            bricks_load <= bricks_load_n;
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed self-checking bench for game_sequencer
module tb_game_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       key_space;
    logic       ball_lost;
    logic       all_cleared;
    logic [2:0] state;
    logic       ball_move;
    logic       ball_load;
    logic       bricks_load;
    logic [1:0] lives;
    logic [1:0] level;
    logic       win;

    int n_assert = 0;
    int n_fail   = 0;

    game_sequencer #(
        .LIVES       (3),
        .NUM_LEVELS  (2),
        .PAUSE_TICKS (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .key_space   (key_space),
        .ball_lost   (ball_lost),
        .all_cleared (all_cleared),
        .state       (state),
        .ball_move   (ball_move),
        .ball_load   (ball_load),
        .bricks_load (bricks_load),
        .lives       (lives),
        .level       (level),
        .win         (win)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press();
        key_space = 1'b0;
        cyc();
        key_space = 1'b1;
        cyc();
        key_space = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b0;
            cyc();
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
    endtask

    task automatic lose_life();
        ball_lost = 1'b1;
        cyc();
        ball_lost = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        tick        = 1'b0;
        key_space   = 1'b0;
        ball_lost   = 1'b0;
        all_cleared = 1'b0;
        cyc();
        cyc();
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_move", 8'(ball_move), 8'd0);
        chk("rst_loads", 8'({ball_load, bricks_load}), 8'd0);
        chk("rst_lives_level_win", 8'({lives, level, win}), 8'd0);
        reset = 1'b1;
        cyc();

        // Start: press and keep the key held for 20 cycles.
        key_space = 1'b1;
        cyc();
        chk("start_state", 8'(state), 8'd1);
        chk("start_lives", 8'(lives), 8'd3);
        chk("start_level", 8'(level), 8'd0);
        chk("start_loads", 8'({ball_load, bricks_load}), 8'b11);
        cyc();
        chk("start_loads_fall", 8'({ball_load, bricks_load}), 8'b00);
        for (int i = 0; i < 19; i++) cyc();
        chk("held_no_play", 8'(state), 8'd1);
        chk("held_no_move", 8'(ball_move), 8'd0);

        press();
        chk("serve_play", 8'(state), 8'd2);
        chk("play_move", 8'(ball_move), 8'd1);

        lose_life();
        chk("lost_state", 8'(state), 8'd3);
        chk("lost_lives", 8'(lives), 8'd2);
        chk("lost_move", 8'(ball_move), 8'd0);
        ticks(3);
        chk("pause_3_ticks", 8'(state), 8'd3);
        ticks(1);
        chk("pause_done_state", 8'(state), 8'd1);
        chk("pause_done_loads", 8'({ball_load, bricks_load}), 8'b10);
        chk("pause_done_lives", 8'(lives), 8'd2);

        press();
        chk("play2", 8'(state), 8'd2);
        ball_lost   = 1'b1;
        all_cleared = 1'b1;
        cyc();
        ball_lost   = 1'b0;
        all_cleared = 1'b0;
        chk("both_clear_state", 8'(state), 8'd4);
        chk("both_clear_lives", 8'(lives), 8'd2);
        ticks(4);
        chk("lvl1_state", 8'(state), 8'd1);
        chk("lvl1_level", 8'(level), 8'd1);
        chk("lvl1_loads", 8'({ball_load, bricks_load}), 8'b11);

        press();
        all_cleared = 1'b1;
        cyc();
        all_cleared = 1'b0;
        chk("clear_last_state", 8'(state), 8'd4);
        ticks(4);
        chk("win_state", 8'(state), 8'd5);
        chk("win_flag", 8'(win), 8'd1);
        chk("win_loads", 8'({ball_load, bricks_load}), 8'b00);
        press();
        chk("end_to_menu", 8'(state), 8'd0);

        // Second game: run out of lives.
        press();
        chk("g2_state", 8'(state), 8'd1);
        chk("g2_lives_level_win", 8'({lives, level, win}), 8'b11000);
        press();
        lose_life();
        ticks(4);
        press();
        lose_life();
        chk("g2_lives1", 8'(lives), 8'd1);
        ticks(4);
        press();
        ball_lost = 1'b1;
        cyc();
        chk("g2_lives0", 8'(lives), 8'd0);
        cyc();
        ball_lost = 1'b0;
        ticks(4);
        chk("lose_state", 8'(state), 8'd5);
        chk("lose_win", 8'(win), 8'd0);
        chk("lose_lives", 8'(lives), 8'd0);
        press();
        chk("lose_to_menu", 8'(state), 8'd0);

        // Reset mid-play with ball_lost also high.
        press();
        press();
        chk("g3_play", 8'(state), 8'd2);
        reset     = 1'b0;
        ball_lost = 1'b1;
        cyc();
        chk("midrst_state", 8'(state), 8'd0);
        chk("midrst_move", 8'(ball_move), 8'd0);
        chk("midrst_loads", 8'({ball_load, bricks_load}), 8'b00);
        chk("midrst_lives_level_win", 8'({lives, level, win}), 8'd0);
        reset     = 1'b1;
        ball_lost = 1'b0;
        cyc();

        // Illegal state code recovers to the menu.
        force dut.state_r = 3'd7;
        #1;
        release dut.state_r;
        cyc();
        chk("illegal_recover", 8'(state), 8'd0);
        chk("illegal_move", 8'(ball_move), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
